bin_to_bcd_seq: RTL and testbench

Parametrised sequential binary-to-BCD converter with a seven-segment output stage. It converts a `WIDTH`-bit unsigned value into `DIGITS` packed BCD digits using iterative shift-and-add-3 (double dabble), one input bit per clock. It reports overflow when the value does not fit in the available digits and drives active-low seven-segment patterns per digit. It replaces the combinational divide/modulo display path wherever wider values or more digits are needed.

---
 rtl/bin_to_bcd_seq.sv | 198 +++++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter (double dabble, one input bit per
//   clock) with a registered active-low seven-segment display stage.
//
//   Parameters
//     WIDTH   : input value width in bits (2..32)
//     DIGITS  : number of BCD output digits (1..10)
//
//   Ports
//     CLOCK_50 : system clock, rising edge
//     RESET    : synchronous, active-high reset
//     start    : conversion request, sampled only while busy=0
//     bin      : unsigned value, captured on the accepted start edge
//     busy     : conversion in progress (exactly WIDTH cycles)
//     done     : one-cycle pulse, results valid from this cycle onward
//     overflow : last result did not fit in DIGITS digits
//     bcd      : packed BCD result, digit 0 (units) in [3:0]
//     hex      : seven-segment patterns, active-low gfedcba, digit 0 in [6:0]
//
//   Optional feature
//     BIN2BCD_BLANK_EN : when defined, zero digits above the most
//                        significant non-zero digit are blanked (digit 0 and
//                        the overflow display are never blanked).
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int BW = 4 * DIGITS;
    localparam int HW = 7 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    // Segment table, active-low gfedcba. Non-decimal codes are dark.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Full display for a result. Also yields the reset display when called
    // with a zero value and no overflow.
    function automatic logic [HW-1:0] display(input logic [BW-1:0] b,
                                              input logic          ovf);
`ifdef BIN2BCD_BLANK_EN
        logic leading;
        leading = 1'b1;
`endif
        display = '0;
        // Walk from the top digit down so leading zeros are known.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ovf) begin
                display[7*i +: 7] = 7'b0111111;
            end else begin
`ifdef BIN2BCD_BLANK_EN
                if (leading && (b[4*i +: 4] == 4'd0) && (i != 0)) begin
                    display[7*i +: 7] = 7'b1111111;
                end else begin
                    leading           = 1'b0;
                    display[7*i +: 7] = seg7(b[4*i +: 4]);
                end
`else
                display[7*i +: 7] = seg7(b[4*i +: 4]);
`endif
            end
        end
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    work_q,  work_d;
    logic             flag_q,  flag_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [BW-1:0]    bcd_q,   bcd_d;
    logic [HW-1:0]    hex_q,   hex_d;
    logic             ovf_q,   ovf_d;

    // One double-dabble step on the working register.
    logic [BW-1:0]    adj;
    logic [BW-1:0]    work_shift;
    logic [WIDTH-1:0] shift_shift;
    logic             carry;
    logic             ovf_next;
    logic [BW-1:0]    bcd_next;

    always_comb begin
        adj = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        // A bit leaving the top digit means the value needs another digit.
        carry       = adj[BW-1];
        work_shift  = {adj[BW-2:0], shift_q[WIDTH-1]};
        shift_shift = {shift_q[WIDTH-2:0], 1'b0};
        ovf_next    = flag_q | carry;
        bcd_next    = ovf_next ? '1 : work_shift;
    end

    always_comb begin
        // NOTE: every variable gets a hold value first so no path through
        // the case statement leaves one unassigned and infers a latch.
        state_d = state_q;
        shift_d = shift_q;
        work_d  = work_q;
        flag_d  = flag_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        hex_d   = hex_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    shift_d = bin;
                    work_d  = '0;
                    flag_d  = 1'b0;
                    cnt_d   = CW'(WIDTH);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                work_d  = work_shift;
                shift_d = shift_shift;
                flag_d  = ovf_next;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    bcd_d   = bcd_next;
                    ovf_d   = ovf_next;
                    hex_d   = display(bcd_next, ovf_next);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            work_q  <= '0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            hex_q   <= display('0, 1'b0);
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            hex_q   <= hex_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == S_SHIFT);
    assign done     = (state_q == S_DONE);
    assign overflow = ovf_q;
    assign bcd      = bcd_q;
    assign hex      = hex_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//   Self-checking bench for bin_to_bcd_seq (WIDTH=10, DIGITS=3).
//   A transaction-level model computes the expected outputs with decimal
//   arithmetic; a compare process checks every cycle after reset, and
//   directed scenarios pin the model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int WIDTH  = 10;
    localparam int DIGITS = 3;

`ifdef BIN2BCD_BLANK_EN
    localparam bit          BLANK   = 1'b1;
    localparam logic [20:0] HEX_RST = {7'b1111111, 7'b1111111, 7'b1000000};
    localparam logic [20:0] HEX_7   = {7'b1111111, 7'b1111111, 7'b1111000};
    localparam logic [20:0] HEX_42  = {7'b1111111, 7'b0011001, 7'b0100100};
`else
    localparam bit          BLANK   = 1'b0;
    localparam logic [20:0] HEX_RST = {7'b1000000, 7'b1000000, 7'b1000000};
    localparam logic [20:0] HEX_7   = {7'b1000000, 7'b1000000, 7'b1111000};
    localparam logic [20:0] HEX_42  = {7'b1000000, 7'b0011001, 7'b0100100};
`endif
    localparam logic [20:0] HEX_255  = {7'b0100100, 7'b0010010, 7'b0010010};
    localparam logic [20:0] HEX_DASH = {7'b0111111, 7'b0111111, 7'b0111111};
    localparam logic [20:0] HEX_999  = {7'b0010000, 7'b0010000, 7'b0010000};
    localparam logic [20:0] HEX_200  = {7'b0100100, 7'b1000000, 7'b1000000};

    logic                clk   = 1'b0;
    logic                rst   = 1'b1;
    logic                start = 1'b0;
    logic [WIDTH-1:0]    bin   = '0;
    logic                busy, done, overflow;
    logic [4*DIGITS-1:0] bcd;
    logic [7*DIGITS-1:0] hex;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd      (bcd),
        .hex      (hex)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [6:0] m_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic int m_pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p *= 10;
        return p;
    endfunction

    function automatic logic [11:0] m_bcd_of(input int v);
        logic [11:0] r = '0;
        if (v >= m_pow10(DIGITS)) return '1;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / m_pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [20:0] m_disp(input int v, input bit ovf);
        logic [20:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf)                             r[7*i +: 7] = 7'b0111111;
            else if (BLANK && i > 0 && v < m_pow10(i)) r[7*i +: 7] = 7'b1111111;
            else                                 r[7*i +: 7] = m_seg((v / m_pow10(i)) % 10);
        end
        return r;
    endfunction

    bit          m_valid = 1'b0;
    int          m_rem   = 0;   // busy cycles remaining
    int          m_val   = 0;
    bit          m_done  = 1'b0;
    bit          m_ovf   = 1'b0;
    logic [11:0] m_bcd   = '0;
    logic [20:0] m_hex   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_rem   = 0;
            m_done  = 1'b0;
            m_ovf   = 1'b0;
            m_bcd   = '0;
            m_hex   = m_disp(0, 1'b0);
        end else if (m_rem == 0) begin
            m_done = 1'b0;
            if (start) begin
                m_rem = WIDTH;
                m_val = int'(bin);
            end
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1'b1;
                m_ovf  = (m_val >= m_pow10(DIGITS));
                m_bcd  = m_bcd_of(m_val);
                m_hex  = m_disp(m_val, m_ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy",     32'(busy),     32'(m_rem != 0));
            check("done",     32'(done),     32'(m_done));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("bcd",      32'(bcd),      32'(m_bcd));
            check("hex",      32'(hex),      32'(m_hex));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic run(input int value, input logic [11:0] exp_bcd,
                       input logic exp_ovf, input logic [20:0] exp_hex,
                       input string tag);
        int busy_cycles = 0;
        bit seen = 1'b0;
        logic [WIDTH-1:0] v;
        v = WIDTH'(value);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) busy_cycles++;
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_len"},  32'(busy_cycles), 32'(WIDTH));
        check({tag, "_bcd"},       32'(bcd), 32'(exp_bcd));
        check({tag, "_ovf"},       32'(overflow), 32'(exp_ovf));
        check({tag, "_hex"},       32'(hex), 32'(exp_hex));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_bcd_hold"},   32'(bcd), 32'(exp_bcd));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dones;
        int cyc;
        int r;
        logic [11:0] got_bcd;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf",  32'(overflow), 32'd0);
        check("rst_bcd",  32'(bcd), 32'd0);
        check("rst_hex",  32'(hex), 32'(HEX_RST));

        run(255,  12'h255, 1'b0, HEX_255,  "v255");
        run(7,    12'h007, 1'b0, HEX_7,    "v7");
        run(1000, 12'hFFF, 1'b1, HEX_DASH, "v1000");
        run(999,  12'h999, 1'b0, HEX_999,  "v999");

        // start during SHIFT is ignored
        @(negedge clk);
        start = 1'b1; bin = 10'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; bin = 10'd45;
        @(negedge clk);
        start = 1'b0;
        dones = 0; got_bcd = '0;
        repeat (20) begin
            if (done) begin dones++; got_bcd = bcd; end
            @(negedge clk);
        end
        check("ign_dones", 32'(dones), 32'd1);
        check("ign_bcd",   32'(got_bcd), 32'h200);
        check("ign_hex",   32'(hex), 32'(HEX_200));

        // reset mid-SHIFT
        @(negedge clk);
        start = 1'b1; bin = 10'd123;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_bcd",  32'(bcd), 32'd0);
        check("mid_rst_hex",  32'(hex), 32'(HEX_RST));
        dones = 0;
        repeat (15) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("mid_rst_no_done", 32'(dones), 32'd0);
        run(42, 12'h042, 1'b0, HEX_42, "v42");

        // back-to-back with start held high
        @(negedge clk);
        start = 1'b1; bin = 10'd99;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done && cyc < 40);
            check("b2b_spacing", 32'(cyc), 32'(WIDTH + 1));
            check("b2b_bcd", 32'(bcd), (k % 2 == 0) ? 32'h099 : 32'h100);
            bin = (k % 2 == 0) ? 10'd100 : 10'd99;
        end
        start = 1'b0;
        repeat (15) @(negedge clk);

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 9));
            case (r)
                0:       bin = 10'd999;
                1:       bin = 10'd1000;
                2:       bin = 10'd0;
                3:       bin = 10'd1023;
                default: bin = WIDTH'($urandom_range(0, 1023));
            endcase
            rst = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (15) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
